// File: rtl/key_pkg.sv
// Game-key table and event encoding shared by the keyboard front end and its arbiter.
// Pure definitions: no latency, no backpressure.
package key_pkg;
    localparam int KEY_MAX = 10;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_REPEAT  = 2'd2
    } evt_t;

    // Index 0 (W) sits in the least significant byte.
    localparam logic [8*KEY_MAX-1:0] KEY_TABLE = {
        8'h2C, 8'h51, 8'h4F, 8'h50, 8'h52, 8'h08, 8'h07, 8'h16, 8'h04, 8'h1A
    };

    function automatic logic [7:0] key_code(input int unsigned k);
        return KEY_TABLE[8*k +: 8];
    endfunction
endpackage

// File: rtl/key_event_arbiter.sv
// Picks the lowest pending key (PRESS > REPEAT > RELEASE) into a registered valid/ready slot; 1-cycle load.
// Backpressure: while valid & !ready the slot holds and nothing is cleared, so events stay pending upstream.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int NUM_KEYS = 10,
    parameter int KW       = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] pend_press_i,
    input  logic [NUM_KEYS-1:0] pend_release_i,
    input  logic [NUM_KEYS-1:0] pend_repeat_i,
    input  logic                evt_ready_i,
    output logic                evt_valid_o,
    output logic [KW-1:0]       evt_key_o,
    output logic [1:0]          evt_type_o,
    output logic [NUM_KEYS-1:0] clr_press_o,
    output logic [NUM_KEYS-1:0] clr_release_o,
    output logic [NUM_KEYS-1:0] clr_repeat_o
);
    logic                valid_q;
    logic [KW-1:0]       key_q;
    evt_t                type_q;
    logic                found;
    logic                load;
    logic [KW-1:0]       sel_key;
    evt_t                sel_type;
    logic [NUM_KEYS-1:0] sel_oh;

    assign load = !valid_q || evt_ready_i;

    // Descending scan so the lowest pending index is the last one to win.
    always_comb begin
        found    = 1'b0;
        sel_key  = '0;
        sel_type = EVT_PRESS;
        sel_oh   = '0;
        for (int k = NUM_KEYS-1; k >= 0; k--) begin
            if (pend_press_i[k] || pend_release_i[k] || pend_repeat_i[k]) begin
                found     = 1'b1;
                sel_key   = KW'(k);
                sel_oh    = '0;
                sel_oh[k] = 1'b1;
                if (pend_press_i[k])       sel_type = EVT_PRESS;
                else if (pend_repeat_i[k]) sel_type = EVT_REPEAT;
                else                       sel_type = EVT_RELEASE;
            end
        end
    end

    always_comb begin
        clr_press_o   = '0;
        clr_release_o = '0;
        clr_repeat_o  = '0;
        if (load && found) begin
            case (sel_type)
                EVT_PRESS:   clr_press_o   = sel_oh;
                EVT_REPEAT:  clr_repeat_o  = sel_oh;
                default:     clr_release_o = sel_oh;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= EVT_PRESS;
        end else if (load) begin
            valid_q <= found;
            if (found) begin
                key_q  <= sel_key;
                type_q <= sel_type;
            end
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_key_o   = key_q;
    assign evt_type_o  = type_q;
endmodule

// File: rtl/key_event_tracker.sv
// Keycode matcher with held state, press/release pulses and a queued event port; strobe->event in 2 cycles.
// Backpressure: stalled events accumulate as per-key pending bits; re-setting one marks evt_overflow. Option: KEY_REPEAT_EN.
module key_event_tracker
    import key_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int NUM_KEYS      = 10,
    parameter int REPEAT_DELAY  = 30,
    parameter int REPEAT_PERIOD = 6
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [8*NUM_SLOTS-1:0]      keycode,
    input  logic                        sample_strobe,
    output logic [NUM_KEYS-1:0]         key_down,
    output logic [NUM_KEYS-1:0]         key_press,
    output logic [NUM_KEYS-1:0]         key_release,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(NUM_KEYS)-1:0] evt_key,
    output logic [1:0]                  evt_type,
    output logic                        evt_overflow
);
    localparam int KW = $clog2(NUM_KEYS);

    if (NUM_KEYS > KEY_MAX || NUM_KEYS < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("key_event_tracker: unsupported parameter set");
    end

    logic [NUM_KEYS-1:0] hit;
    logic [NUM_KEYS-1:0] down_q, press_q, release_q, rpt_q;
    logic [NUM_KEYS-1:0] pend_p_q, pend_r_q, pend_t_q;
    logic [NUM_KEYS-1:0] pend_p_d, pend_r_d, pend_t_d;
    logic [NUM_KEYS-1:0] clr_p, clr_r, clr_t;
    logic                ovf_q, ovf_d;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (keycode[8*s +: 8] != 8'h00 && keycode[8*s +: 8] == key_code(k))
                    hit[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            down_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= sample_strobe ? (hit & ~down_q) : '0;
            release_q <= sample_strobe ? (~hit & down_q) : '0;
            if (sample_strobe) down_q <= hit;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int CW = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] rpt_d;
    logic [CW-1:0]       nxt;

    // Count includes the press strobe; on reaching DELAY+PERIOD it rewinds to DELAY.
    always_comb begin
        rpt_d = '0;
        nxt   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (sample_strobe) begin
                if (hit[k]) begin
                    nxt = down_q[k] ? cnt_q[k] + CW'(1) : CW'(1);
                    if (nxt == CW'(REPEAT_DELAY)) rpt_d[k] = 1'b1;
                    if (nxt == CW'(REPEAT_DELAY + REPEAT_PERIOD)) begin
                        rpt_d[k] = 1'b1;
                        nxt      = CW'(REPEAT_DELAY);
                    end
                    cnt_d[k] = nxt;
                end else begin
                    cnt_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rpt_q <= '0;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
        end else begin
            rpt_q <= rpt_d;
            for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
        end
    end
`else
    assign rpt_q = '0;
`endif

    // A bit set while already pending and not being drained is the only lossy case.
    always_comb begin
        pend_p_d = (pend_p_q & press_q)   | ((pend_p_q | press_q)   & ~clr_p);
        pend_r_d = (pend_r_q & release_q) | ((pend_r_q | release_q) & ~clr_r);
        pend_t_d = (pend_t_q & rpt_q)     | ((pend_t_q | rpt_q)     & ~clr_t);
        ovf_d    = ovf_q
                 | (|(pend_p_q & press_q & ~clr_p))
                 | (|(pend_r_q & release_q & ~clr_r))
                 | (|(pend_t_q & rpt_q & ~clr_t));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_p_q <= '0;
            pend_r_q <= '0;
            pend_t_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_p_q <= pend_p_d;
            pend_r_q <= pend_r_d;
            pend_t_q <= pend_t_d;
            ovf_q    <= ovf_d;
        end
    end

    key_event_arbiter #(
        .NUM_KEYS (NUM_KEYS),
        .KW       (KW)
    ) u_arb (
        .clk_i          (Clk),
        .rst_i          (Reset),
        .pend_press_i   (pend_p_q | press_q),
        .pend_release_i (pend_r_q | release_q),
        .pend_repeat_i  (pend_t_q | rpt_q),
        .evt_ready_i    (evt_ready),
        .evt_valid_o    (evt_valid),
        .evt_key_o      (evt_key),
        .evt_type_o     (evt_type),
        .clr_press_o    (clr_p),
        .clr_release_o  (clr_r),
        .clr_repeat_o   (clr_t)
    );

    assign key_down     = down_q;
    assign key_press    = press_q;
    assign key_release  = release_q;
    assign evt_overflow = ovf_q;
endmodule
